// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues single-cycle requests to instruction memory and
// holds the fetched word for the core. Optional WAIT timeout enabled by FETCH_TIMEOUT_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic [6:0]  opcode_o,
    output logic [31:0] pc_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic        fetch_err_o
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        VALID,
        ERR
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] instr_reg, instr_next;
    logic        err_reg, err_next;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_reg, cnt_next;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            pc_reg    <= RESET_PC;
            instr_reg <= NOP;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            instr_reg <= instr_next;
            err_reg   <= err_next;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end
`endif

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        instr_next = instr_reg;
        err_next   = err_reg;
`ifdef FETCH_TIMEOUT_EN
        cnt_next   = cnt_reg;
`endif
        case (state_reg)
            IDLE: state_next = REQ;
            REQ: begin
                state_next = WAIT;
`ifdef FETCH_TIMEOUT_EN
                cnt_next   = '0;
`endif
            end
            WAIT: begin
                // A response always wins over a timeout expiring in the same cycle.
                if (imem_rvalid_i) begin
                    instr_next = imem_rdata_i;
                    state_next = VALID;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (cnt_reg == CNT_LAST) begin
                    cnt_next   = cnt_reg + 1'b1;
                    err_next   = 1'b1;
                    state_next = ERR;
                end else begin
                    cnt_next   = cnt_reg + 1'b1;
                end
`endif
            end
            VALID: begin
                if (instr_ready_i) begin
                    if (branch_taken_i) begin
                        pc_next = branch_target_i;
                        if (branch_target_i[1:0] != 2'b00) begin
                            err_next   = 1'b1;
                            state_next = ERR;
                        end else begin
                            state_next = REQ;
                        end
                    end else begin
                        pc_next    = pc_reg + 32'd4;
                        state_next = REQ;
                    end
                end
            end
            ERR:     state_next = ERR;
            default: state_next = IDLE;
        endcase
    end

    assign imem_req_o    = (state_reg == REQ);
    assign imem_addr_o   = pc_reg;
    assign instr_o       = instr_reg;
    assign opcode_o      = instr_reg[6:0];
    assign pc_o          = pc_reg;
    assign instr_valid_o = (state_reg == VALID);
    assign fetch_err_o   = err_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit; timeout steps run only when
// FETCH_TIMEOUT_EN is defined.
module tb_instr_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] instr_o;
    logic [6:0]  opcode_o;
    logic [31:0] pc_o;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic        fetch_err_o;

    int checks = 0;
    int errors = 0;

    instr_fetch_unit #(
        .RESET_PC      (32'h0000_0000),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_rvalid_i  (imem_rvalid_i),
        .imem_rdata_i   (imem_rdata_i),
        .instr_o        (instr_o),
        .opcode_o       (opcode_o),
        .pc_o           (pc_o),
        .instr_valid_o  (instr_valid_o),
        .instr_ready_i  (instr_ready_i),
        .branch_taken_i (branch_taken_i),
        .branch_target_i(branch_target_i),
        .fetch_err_o    (fetch_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-14s observed %h expected %h", tag, obs, exp);
    endtask

    // Entered with the DUT in REQ; leaves it in VALID holding 'data'.
    task automatic do_fetch(input string tag, input logic [31:0] addr, input logic [31:0] data);
        check({tag, "_req"}, {31'd0, imem_req_o}, 32'd1);
        check({tag, "_addr"}, imem_addr_o, addr);
        tick();
        check({tag, "_wait_req"}, {31'd0, imem_req_o}, 32'd0);
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = data;
        tick();
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'hFFFF_FFFF;
        check({tag, "_valid"}, {31'd0, instr_valid_o}, 32'd1);
        check({tag, "_instr"}, instr_o, data);
        check({tag, "_opcode"}, {25'd0, opcode_o}, {25'd0, data[6:0]});
        check({tag, "_pc"}, pc_o, addr);
    endtask

    task automatic accept(input logic taken, input logic [31:0] target);
        instr_ready_i   = 1'b1;
        branch_taken_i  = taken;
        branch_target_i = target;
        tick();
        instr_ready_i   = 1'b0;
        branch_taken_i  = 1'b0;
        branch_target_i = 32'h0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i           = 1'b1;
        imem_rvalid_i   = 1'b0;
        imem_rdata_i    = 32'h0;
        instr_ready_i   = 1'b0;
        branch_taken_i  = 1'b0;
        branch_target_i = 32'h0;

        // Reset state
        do_reset();
        check("rst_pc", pc_o, 32'h0);
        check("rst_instr", instr_o, 32'h0000_0013);
        check("rst_opcode", {25'd0, opcode_o}, 32'h13);
        check("rst_valid", {31'd0, instr_valid_o}, 32'd0);
        check("rst_req", {31'd0, imem_req_o}, 32'd0);
        check("rst_err", {31'd0, fetch_err_o}, 32'd0);

        // First fetch, then sequential accept
        tick();
        do_fetch("f0", 32'h0, 32'h00A0_0093);
        accept(1'b0, 32'h0);
        check("f0_next_valid", {31'd0, instr_valid_o}, 32'd0);

        // Hold in VALID for 5 cycles while branch inputs and rvalid wiggle
        do_fetch("f1", 32'h4, 32'h0010_8113);
        for (int i = 0; i < 5; i++) begin
            branch_taken_i  = 1'b1;
            branch_target_i = 32'h0000_0200 + 32'(i);
            imem_rvalid_i   = 1'b1;
            imem_rdata_i    = 32'hDEAD_BEEF;
            tick();
            check("hold_valid", {31'd0, instr_valid_o}, 32'd1);
            check("hold_req", {31'd0, imem_req_o}, 32'd0);
            check("hold_instr", instr_o, 32'h0010_8113);
            check("hold_pc", pc_o, 32'h4);
        end
        imem_rvalid_i = 1'b0;
        accept(1'b0, 32'h0);

        // Aligned branch redirect
        do_fetch("f2", 32'h8, 32'h0000_006F);
        accept(1'b1, 32'h0000_0100);
        check("br_pc", pc_o, 32'h100);
        do_fetch("f3", 32'h100, 32'h0000_0063);

        // Branch to top of address space, then sequential wrap to 0
        accept(1'b1, 32'hFFFF_FFFC);
        do_fetch("f4", 32'hFFFF_FFFC, 32'h0000_0013);
        accept(1'b0, 32'h0);
        check("wrap_addr", imem_addr_o, 32'h0);
        do_fetch("f5", 32'h0, 32'h0000_0063);

        // Misaligned branch target -> sticky error
        accept(1'b1, 32'h0000_0102);
        check("mis_err", {31'd0, fetch_err_o}, 32'd1);
        check("mis_pc", pc_o, 32'h102);
        for (int i = 0; i < 4; i++) begin
            imem_rvalid_i = 1'b1;
            instr_ready_i = 1'b1;
            tick();
            check("err_sticky", {31'd0, fetch_err_o}, 32'd1);
            check("err_req", {31'd0, imem_req_o}, 32'd0);
            check("err_valid", {31'd0, instr_valid_o}, 32'd0);
        end
        imem_rvalid_i = 1'b0;
        instr_ready_i = 1'b0;
        do_reset();
        check("err_rst_pc", pc_o, 32'h0);
        check("err_rst_err", {31'd0, fetch_err_o}, 32'd0);

        // Reset during WAIT; a late response must be ignored
        tick();
        tick();
        check("w_in_wait_req", {31'd0, imem_req_o}, 32'd0);
        rst_i = 1'b1;
        tick();
        rst_i         = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hDEAD_BEEF;
        check("wr_idle_pc", pc_o, 32'h0);
        check("wr_idle_instr", instr_o, 32'h0000_0013);
        check("wr_idle_req", {31'd0, imem_req_o}, 32'd0);
        tick();
        check("wr_req", {31'd0, imem_req_o}, 32'd1);
        check("wr_instr", instr_o, 32'h0000_0013);
        imem_rvalid_i = 1'b0;
        tick();
        check("wr_wait_valid", {31'd0, instr_valid_o}, 32'd0);
        check("wr_wait_instr", instr_o, 32'h0000_0013);
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'h1234_5037;
        tick();
        imem_rvalid_i = 1'b0;
        check("wr_valid", {31'd0, instr_valid_o}, 32'd1);
        check("wr_opcode", {25'd0, opcode_o}, 32'h37);
        accept(1'b0, 32'h0);

`ifdef FETCH_TIMEOUT_EN
        // No response: error after 16 WAIT cycles
        check("to_req", {31'd0, imem_req_o}, 32'd1);
        tick();
        for (int i = 0; i < 15; i++) begin
            tick();
            check("to_pending", {31'd0, fetch_err_o}, 32'd0);
        end
        tick();
        check("to_err", {31'd0, fetch_err_o}, 32'd1);
        check("to_req_off", {31'd0, imem_req_o}, 32'd0);
        do_reset();
        // Response in the 16th WAIT cycle wins
        tick();
        tick();
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'h0000_0033;
        tick();
        imem_rvalid_i = 1'b0;
        check("to_late_err", {31'd0, fetch_err_o}, 32'd0);
        check("to_late_valid", {31'd0, instr_valid_o}, 32'd1);
        check("to_late_instr", instr_o, 32'h0000_0033);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
